// File: rtl/pet_io_pkg.sv
// Shared types and board defaults for the pet feeder I/O blocks.
// Actuator FSM states, 50 MHz timing defaults, counter sizing helper.
package pet_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } act_state_t;

  // 0.5 s on, 0.25 s off at the 50 MHz board clock
  localparam int unsigned ON_CYCLES_DFLT  = 25_000_000;
  localparam int unsigned GAP_CYCLES_DFLT = 12_500_000;

  // Width able to hold max(a,b)-1; never below one bit
  function automatic int unsigned cnt_w(
    input int unsigned a,
    input int unsigned b
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level already synchronous to clk.
// Ports: clk, reset (sync, high), in (level), out_edge (in & ~last in).
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out_edge
);

  logic q;

  // Resets high so a level held through reset is not seen as an edge
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b1;
    else       q <= in;
  end

  assign out_edge = in & ~q;

endmodule

// File: rtl/actuator_pulse.sv
// Fixed on-time / minimum off-time pulse driver with request queue.
// Ports: clk, reset, trigger, cancel -> out, busy, pending, done, overflow.
module actuator_pulse
  import pet_io_pkg::*;
#(
  parameter int unsigned ON_CYCLES   = ON_CYCLES_DFLT,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DFLT,
  parameter int unsigned MAX_PENDING = 3,
  localparam int unsigned PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trigger,
  input  logic          cancel,
  output logic          out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          done,
  output logic          overflow
);

  localparam int unsigned CW = cnt_w(ON_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PMAX   = PW'(MAX_PENDING);

  act_state_t    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [PW-1:0] pend_n;
  logic          done_n, ovf_n;
  logic          rise, last, enq;

  rise_detect u_rise (
    .clk      (clk),
    .reset    (reset),
    .in       (trigger),
    .out_edge (rise)
  );

  assign last = (cnt_q == '0);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pend_n  = pending;
    done_n  = 1'b0;
    ovf_n   = 1'b0;
    enq     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise && !cancel) begin
          state_n = ON;
          cnt_n   = ON_LD;
        end
      end
      ON: begin
        enq = 1'b1;
        if (last) begin
          state_n = GAP;
          cnt_n   = GAP_LD;
          done_n  = !cancel;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (!last) begin
          cnt_n = cnt_q - CW'(1);
          enq   = 1'b1;
        end else if (rise && !cancel) begin
          // Edge replaces the dequeued request: count unchanged
          state_n = ON;
          cnt_n   = ON_LD;
        end else if (pending != '0) begin
          state_n = ON;
          cnt_n   = ON_LD;
          pend_n  = pending - PW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort always restarts a full off-time and wins over any edge
    if (cancel && state_q != IDLE) begin
      state_n = GAP;
      cnt_n   = GAP_LD;
      pend_n  = '0;
    end else if (enq && rise) begin
      if (pending == PMAX) ovf_n  = 1'b1;
      else                 pend_n = pending + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pending  <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      pending  <= pend_n;
      out      <= (state_n == ON);
      busy     <= (state_n != IDLE);
      done     <= done_n;
      overflow <= ovf_n;
    end
  end

endmodule

// File: tb/tb_actuator_pulse.sv
// Directed bench for actuator_pulse, ON=4 GAP=2 MAX_PENDING=2.
// Cycle c is the clock period that ends at posedge c.
module tb_actuator_pulse;

  localparam int PW = $clog2(2 + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          trigger;
  logic          cancel;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          done;
  logic          overflow;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  actuator_pulse #(
    .ON_CYCLES   (4),
    .GAP_CYCLES  (2),
    .MAX_PENDING (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trigger  (trigger),
    .cancel   (cancel),
    .out      (out),
    .busy     (busy),
    .pending  (pending),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) adv();
  endtask

  task automatic do_reset(input logic trig);
    trigger = trig;
    cancel  = 1'b0;
    reset   = 1'b1;
    adv();
    adv();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] exp_out;
    int ovf_cnt;
    int rises;
    int done_seen;
    logic prev;

    // Reset values
    do_reset(1'b0);
    chk("rst_out",  out,      0);
    chk("rst_busy", busy,     0);
    chk("rst_pend", pending,  0);
    chk("rst_done", done,     0);
    chk("rst_ovf",  overflow, 0);

    // Single request, edge at posedge 10
    go_to(10);
    trigger = 1'b1;
    for (int c = 11; c <= 14; c++) begin
      go_to(c);
      chk("s_out_on", out, 1);
      trigger = 1'b0;
    end
    go_to(15);
    chk("s_out15",  out,  0);
    chk("s_done15", done, 1);
    go_to(16);
    chk("s_done16", done, 0);
    chk("s_busy16", busy, 1);
    go_to(17);
    chk("s_busy17", busy, 0);

    // Queued requests: edges at 10, 12, 14
    do_reset(1'b0);
    exp_out = 20'h0F3CF;
    ovf_cnt = 0;
    for (int c = 10; c <= 30; c++) begin
      go_to(c);
      if (c >= 11) chk("q_out", out, int'(exp_out[c-11]));
      if (overflow) ovf_cnt++;
      if (c == 13) chk("q_pend13", pending, 1);
      if (c == 15) chk("q_pend15", pending, 2);
      if (c == 17) chk("q_pend17", pending, 1);
      if (c == 23) chk("q_pend23", pending, 0);
      if (c == 29) chk("q_busy29", busy, 0);
      trigger = (c == 10 || c == 12 || c == 14);
    end
    chk("q_no_ovf", ovf_cnt, 0);

    // Overflow: edges at 10,12,14,16(swap with dequeue),18(dropped)
    do_reset(1'b0);
    ovf_cnt = 0;
    rises = 0;
    prev = 1'b0;
    for (int c = 10; c <= 40; c++) begin
      go_to(c);
      if (out && !prev) rises++;
      prev = out;
      if (overflow) ovf_cnt++;
      if (c == 17) chk("o_pend17", pending, 2);
      if (c == 19) chk("o_ovf19",  overflow, 1);
      if (c == 19) chk("o_pend19", pending, 2);
      if (c == 23) chk("o_pend23", pending, 1);
      if (c == 29) chk("o_pend29", pending, 0);
      if (c == 34) chk("o_busy34", busy, 1);
      if (c == 35) chk("o_busy35", busy, 0);
      trigger = (c == 10 || c == 12 || c == 14 || c == 16 || c == 18);
    end
    chk("o_ovf_cnt", ovf_cnt, 1);
    chk("o_pulses",  rises,   4);

    // Cancel in ON at posedge 12
    do_reset(1'b0);
    done_seen = 0;
    for (int c = 10; c <= 16; c++) begin
      go_to(c);
      if (done) done_seen++;
      if (c == 12) chk("c_out12",  out,  1);
      if (c == 13) chk("c_out13",  out,  0);
      if (c == 14) chk("c_busy14", busy, 1);
      if (c == 15) chk("c_busy15", busy, 0);
      if (c == 15) chk("c_pend15", pending, 0);
      trigger = (c == 10);
      cancel  = (c == 12);
    end
    chk("c_no_done", done_seen, 0);

    // Cancel together with an edge during ON
    do_reset(1'b0);
    rises = 0;
    prev = 1'b0;
    for (int c = 10; c <= 20; c++) begin
      go_to(c);
      if (c > 12 && out && !prev) rises++;
      prev = out;
      if (c == 13) chk("ce_pend13", pending, 0);
      if (c == 13) chk("ce_out13",  out, 0);
      if (c == 15) chk("ce_busy15", busy, 0);
      trigger = (c == 10 || c == 12);
      cancel  = (c == 12);
    end
    chk("ce_no_pulse", rises, 0);

    // Trigger held high through reset
    do_reset(1'b1);
    go_to(3);
    chk("h_out3",  out,  0);
    chk("h_busy3", busy, 0);
    go_to(8);
    chk("h_out8",  out,  0);
    chk("h_busy8", busy, 0);

    // Reset mid-ON with one request queued
    do_reset(1'b0);
    go_to(10);
    trigger = 1'b1;
    go_to(11);
    trigger = 1'b0;
    go_to(12);
    trigger = 1'b1;
    go_to(13);
    chk("r_pend13", pending, 1);
    chk("r_out13",  out, 1);
    reset = 1'b1;
    go_to(14);
    chk("r_out14",  out, 0);
    chk("r_busy14", busy, 0);
    chk("r_pend14", pending, 0);
    reset   = 1'b0;
    trigger = 1'b0;
    go_to(16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
